operation_sequencer: RTL and testbench

//  Instruction issuer that drives operation_machine's operand/index1/index2/index3/value bus.

---
 rtl/operation_sequencer_pkg.sv | 35 +++
 rtl/operation_sequencer_if.sv | 14 +
 rtl/operation_sequencer_prog_mem.sv | 24 ++
 rtl/operation_sequencer.sv | 127 ++++++++++++
 tb/tb_operation_sequencer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/operation_sequencer_pkg.sv
// Shared opcodes, sequencer state encoding and instruction-field width helpers
// for operation_sequencer and its program memory.
package operation_sequencer_pkg;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LOAD1 = 3'b001;
  localparam logic [2:0] OP_LOAD2 = 3'b010;
  localparam logic [2:0] OP_ADD   = 3'b011;
  localparam logic [2:0] OP_MULT  = 3'b100;
  localparam logic [2:0] OP_NEG   = 3'b101;
  localparam logic [2:0] OP_ABS   = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } seq_state_t;

  // Two extra index bits beyond the stack address leave headroom for the machine.
  function automatic int idx_w(input int stack);
    return $clog2(stack) + 2;
  endfunction

  function automatic int instr_w(input int n, input int stack);
    return 3 * idx_w(stack) + n + 3;
  endfunction

  function automatic logic is_arith(input logic [2:0] op);
    return (op >= OP_ADD) && (op <= OP_ABS);
  endfunction

endpackage

// File: rtl/operation_sequencer_if.sv
// Instruction bus between operation_sequencer (master) and operation_machine (slave).
interface operation_sequencer_if #(
  parameter int N  = 32,
  parameter int IW = 5
);
  logic [2:0]    operand;
  logic [IW-1:0] index1;
  logic [IW-1:0] index2;
  logic [IW-1:0] index3;
  logic [N-1:0]  value;

  modport master (output operand, index1, index2, index3, value);
  modport slave  (input  operand, index1, index2, index3, value);
endinterface

// File: rtl/operation_sequencer_prog_mem.sv
// Program store: one write port, one registered read port, contents survive reset.
module seq_prog_mem #(
  parameter int W     = 50,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/operation_sequencer.sv
// Steps through a writable program and drives operation_machine's instruction bus.
// Optional SEQ_STEP_EN: pause after every issued instruction until cont is sampled high.
module operation_sequencer
  import operation_sequencer_pkg::*;
#(
  parameter int N          = 32,
  parameter int Q          = 16,
  parameter int STACK      = 5,
  parameter int PROG_DEPTH = 16,
  parameter int OP_HOLD    = 2,
  localparam int IW  = idx_w(STACK),
  localparam int IWD = instr_w(N, STACK),
  localparam int PW  = $clog2(PROG_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      cont,
  input  logic                      prog_we,
  input  logic [PW-1:0]             prog_addr,
  input  logic [IWD-1:0]            prog_data,
  operation_sequencer_if.master     bus,
  output logic                      busy,
  output logic                      done
);
  localparam int HW = (OP_HOLD > 1) ? $clog2(OP_HOLD) : 1;

  seq_state_t     r_state, w_next;
  logic [PW-1:0]  r_pc;
  logic [HW-1:0]  r_hold;
  logic [IWD-1:0] w_instr;
  logic [2:0]     w_op;
  logic           w_hold_last, w_last_pc, w_advance, w_we;

  // Writes only land while idle, so the read data stays stable through a hold.
  assign w_we = prog_we && (r_state == S_IDLE);

  seq_prog_mem #(.W(IWD), .DEPTH(PROG_DEPTH), .AW(PW)) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (prog_addr),
    .i_wdata (prog_data),
    .i_re    (r_state == S_FETCH),
    .i_raddr (r_pc),
    .o_rdata (w_instr)
  );

  assign w_op        = w_instr[2:0];
  assign w_last_pc   = (r_pc == PW'(PROG_DEPTH - 1));
  assign w_hold_last = is_arith(w_op) ? (r_hold == HW'(OP_HOLD - 1)) : 1'b1;

`ifdef SEQ_STEP_EN
  logic w_unused;
  assign w_unused  = (Q < 0);
  assign w_advance = (r_state == S_PAUSE) && cont;
`else
  logic w_unused;
  assign w_unused  = cont ^ (Q < 0);
  assign w_advance = (r_state == S_ISSUE) && (w_op != OP_HALT) && w_hold_last;
`endif

  // ---- state register, pc and hold counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && start)
        r_pc <= '0;
      else if (w_advance && !w_last_pc)
        r_pc <= r_pc + PW'(1);
      if ((r_state == S_ISSUE) && !w_hold_last)
        r_hold <= r_hold + HW'(1);
      else
        r_hold <= '0;
    end
  end

  // ---- next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_FETCH;
      S_FETCH: w_next = S_ISSUE;
      S_ISSUE: begin
        if (w_op == OP_HALT)
          w_next = S_DONE;
        else if (w_hold_last)
`ifdef SEQ_STEP_EN
          w_next = S_PAUSE;
`else
          w_next = w_last_pc ? S_DONE : S_FETCH;
`endif
      end
      S_PAUSE: begin
`ifdef SEQ_STEP_EN
        if (w_advance) w_next = w_last_pc ? S_DONE : S_FETCH;
`else
        w_next = S_IDLE;
`endif
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---- bus and status outputs
  always_comb begin
    bus.operand = OP_NOP;
    bus.index1  = '0;
    bus.index2  = '0;
    bus.index3  = '0;
    bus.value   = '0;
    busy        = (r_state != S_IDLE);
    done        = (r_state == S_DONE);
    if ((r_state == S_ISSUE) && (w_op != OP_HALT)) begin
      bus.operand = w_op;
      bus.index1  = w_instr[3 +: IW];
      bus.index2  = w_instr[3 + IW +: IW];
      bus.index3  = w_instr[3 + 2*IW +: IW];
      bus.value   = w_instr[3 + 3*IW +: N];
    end
  end

endmodule

// File: tb/tb_operation_sequencer.sv
// Scoreboard bench: a program-level model predicts the per-cycle bus trace,
// a monitor checks it whenever the sequencer reports busy.
module tb_operation_sequencer;
  localparam int N       = 32;
  localparam int STACK   = 5;
  localparam int PD      = 16;
  localparam int OP_HOLD = 2;
  localparam int IW      = 5;
  localparam int IWD     = 3*IW + N + 3;
  localparam int PW      = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic cont = 1'b0;
  logic prog_we = 1'b0;
  logic [PW-1:0]  prog_addr = '0;
  logic [IWD-1:0] prog_data = '0;
  logic busy, done;

  operation_sequencer_if #(.N(N), .IW(IW)) bus ();

  operation_sequencer #(
    .N(N), .Q(16), .STACK(STACK), .PROG_DEPTH(PD), .OP_HOLD(OP_HOLD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .bus(bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    op;
    logic [IW-1:0] i1, i2, i3;
    logic [N-1:0]  val;
  } ins_t;

  typedef struct packed {
    ins_t bus_v;
    logic dn;
  } exp_t;

  ins_t mem_m [PD];
  exp_t exp_q [$];
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  function automatic ins_t mk(input logic [2:0] op, input int a, input int b,
                              input int c, input logic [N-1:0] v);
    ins_t x;
    x.op = op; x.i1 = IW'(a); x.i2 = IW'(b); x.i3 = IW'(c); x.val = v;
    return x;
  endfunction

  function automatic logic [IWD-1:0] enc(input ins_t x);
    return {x.val, x.i3, x.i2, x.i1, x.op};
  endfunction

  function automatic ins_t rnd_ins();
    ins_t x;
    x.op = 3'($urandom_range(0, 7));
    if (x.op == 3'b111 && $urandom_range(0, 3) != 0) x.op = 3'b001;
    x.i1 = IW'($urandom); x.i2 = IW'($urandom); x.i3 = IW'($urandom);
    x.val = N'($urandom);
    return x;
  endfunction

  // Reference: FETCH shows NOP, ISSUE shows the entry for its hold length,
  // HALT shows NOP and ends, the last entry ends without wrapping, then DONE.
  function automatic void build_trace();
    exp_t nop_e;
    exp_t e;
    int   hold;
    nop_e = '0;
    for (int pc = 0; pc < PD; pc++) begin
      exp_q.push_back(nop_e);
      if (mem_m[pc].op == 3'b111) begin
        exp_q.push_back(nop_e);
        break;
      end
      e.bus_v = mem_m[pc];
      e.dn    = 1'b0;
      hold = (mem_m[pc].op >= 3'd3 && mem_m[pc].op <= 3'd6) ? OP_HOLD : 1;
      for (int h = 0; h < hold; h++) exp_q.push_back(e);
`ifdef SEQ_STEP_EN
      exp_q.push_back(nop_e);
`endif
    end
    e = '0;
    e.dn = 1'b1;
    exp_q.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic wr(input int a, input ins_t x);
    prog_we = 1'b1; prog_addr = PW'(a); prog_data = enc(x);
    mem_m[a] = x;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    exp_q.delete();
    mon_en = 1'b1;
  endtask

  // Start a run, optionally writing entry 0 in the start cycle or poking
  // start/prog_we while busy, and wait for the scoreboard to drain.
  task automatic run(input bit wr_start, input ins_t w0, input bit poke);
    int n;
    if (wr_start) begin
      mem_m[0] = w0;
      prog_we = 1'b1; prog_addr = '0; prog_data = enc(w0);
    end
    build_trace();
    start = 1'b1;
    tick();
    start = 1'b0; prog_we = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      if (poke && n == 2) begin
        start = 1'b1; prog_we = 1'b1; prog_addr = '0; prog_data = ~enc(mem_m[0]);
      end else begin
        start = 1'b0; prog_we = 1'b0;
      end
      tick();
      n++;
    end
    start = 1'b0; prog_we = 1'b0;
    if (exp_q.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL run_timeout: %0d entries left, required 0", exp_q.size());
      do_reset();
    end else begin
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_done", 64'(done), 64'd0);
    end
  endtask

  task automatic reset_mid(input int k);
    exp_q.delete();
    mon_en = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (k) tick();
    rst = 1'b0;
    tick();
    chk("rst_operand", 64'(bus.operand), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("rst_after_busy", 64'(busy), 64'd0);
    chk("rst_after_done", 64'(done), 64'd0);
    mon_en = 1'b1;
  endtask

  exp_t m_act, m_exp;
  always @(negedge clk) begin
    if (mon_en && busy) begin
      m_act.bus_v = {bus.operand, bus.index1, bus.index2, bus.index3, bus.value};
      m_act.dn    = done;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL bus_extra: got op=%0h done=%0b while busy, required idle",
                 m_act.bus_v.op, m_act.dn);
      end else begin
        m_exp = exp_q.pop_front();
        if (m_act !== m_exp) begin
          n_fail++;
          $display("FAIL bus_trace: got op=%0h i=%0h/%0h/%0h v=%0h done=%0b, required op=%0h i=%0h/%0h/%0h v=%0h done=%0b",
                   m_act.bus_v.op, m_act.bus_v.i1, m_act.bus_v.i2, m_act.bus_v.i3, m_act.bus_v.val, m_act.dn,
                   m_exp.bus_v.op, m_exp.bus_v.i1, m_exp.bus_v.i2, m_exp.bus_v.i3, m_exp.bus_v.val, m_exp.dn);
        end
      end
    end
  end

  // Step mode advances on every PAUSE; otherwise cont is noise the DUT must ignore.
  initial begin
    forever begin
      @(posedge clk);
      #1;
`ifdef SEQ_STEP_EN
      cont = 1'b1;
`else
      cont = 1'($urandom_range(0, 1));
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  ins_t t2 [4];
  initial begin
    tick(); tick();
    chk("reset_operand", 64'(bus.operand), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    rst = 1'b1;
    mon_en = 1'b1;
    tick();

    t2[0] = mk(3'b001, 1, 0, 0, 32'h0001_8000);
    t2[1] = mk(3'b010, 0, 2, 0, 32'h0002_0000);
    t2[2] = mk(3'b011, 1, 2, 3, 32'h0);
    t2[3] = mk(3'b111, 0, 0, 0, 32'h0);
    for (int a = 0; a < 4; a++) wr(a, t2[a]);

    reset_mid(3);
    run(1'b0, t2[0], 1'b0);

    // Busy-time start/write are ignored; the rerun still sees the old entry 0.
    run(1'b0, t2[0], 1'b1);
    run(1'b0, t2[0], 1'b0);

    // Reset in the middle of the ADD hold, memory retained.
    reset_mid(5);
    run(1'b0, t2[0], 1'b0);

    for (int a = 0; a < PD; a++) wr(a, mk(3'b001, a, 0, 0, N'(a * 32'h101)));
    run(1'b0, t2[0], 1'b0);

    for (int r = 0; r < 8; r++) begin
      for (int a = 0; a < PD; a++) wr(a, rnd_ins());
      run(r[0], rnd_ins(), r == 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
